// File: rtl/pitch_read_interp.sv
// rtl/pitch_read_interp.sv - fractional-rate interpolating delay-line reader
//
// Owns a circular sample buffer written once per accepted input sample. Each
// accepted sample also triggers one read at a fractional read pointer
// (rd_phase). The two neighbouring buffer entries are linearly interpolated to
// produce one output sample. The read pointer then advances by the ratio
// latched at acceptance.
//
// Ports:
//   clock      in   rising-edge clock
//   reset_n    in   synchronous active-low reset; restarts the buffer clear
//   in_valid   in   input sample strobe (accepted only when idle)
//   in_data    in   signed input sample
//   ratio      in   read-pointer increment, FRACWIDTH fractional bits
//   out_valid  out  one-cycle strobe per accepted sample
//   out_data   out  signed interpolated sample, held between strobes
//   busy       out  high whenever a new sample cannot be accepted
//   dropped    out  sticky: a sample arrived while busy (cleared by reset)

module pitch_read_interp #(
  parameter int DATAWIDTH  = 16,
  parameter int ADDRWIDTH  = 10,
  parameter int FRACWIDTH  = 8,
  parameter int RATIOWIDTH = 12
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [DATAWIDTH-1:0]  in_data,
  input  logic [RATIOWIDTH-1:0] ratio,
  output logic                  out_valid,
  output logic [DATAWIDTH-1:0]  out_data,
  output logic                  busy,
  output logic                  dropped
);

  localparam int DEPTH = 1 << ADDRWIDTH;
  localparam int PW    = ADDRWIDTH + FRACWIDTH;
  localparam int DW1   = DATAWIDTH + 1;
  localparam int MW    = DATAWIDTH + FRACWIDTH + 2;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_READ0,
    S_READ1,
    S_MUL,
    S_OUT
  } state_t;

  state_t state, state_next;

  // Sample buffer: one write port, one registered read port.
  logic [DATAWIDTH-1:0] mem [DEPTH];
  logic [DATAWIDTH-1:0] rd_data;
  logic                 mem_we;
  logic [ADDRWIDTH-1:0] mem_waddr;
  logic [ADDRWIDTH-1:0] mem_raddr;
  logic [DATAWIDTH-1:0] mem_wdata;

  logic [ADDRWIDTH-1:0]  clr_addr;
  logic [ADDRWIDTH-1:0]  wr_ptr;
  logic [PW-1:0]         rd_phase;
  logic                  accept;

  // Per-transaction datapath registers (no reset needed: always loaded
  // before use within a transaction).
  logic [ADDRWIDTH-1:0]        idx_q;
  logic [FRACWIDTH-1:0]        frac_q;
  logic [RATIOWIDTH-1:0]       ratio_q;
  logic signed [DATAWIDTH-1:0] a_q;
  logic signed [MW-1:0]        prod_q;

  logic signed [DW1-1:0]       diff;
  logic signed [MW-1:0]        diff_ext;
  logic signed [MW-1:0]        frac_ext;
  logic signed [MW-1:0]        prod_next;
  logic signed [MW-1:0]        shifted;
  logic signed [MW-1:0]        a_ext;
  logic [DATAWIDTH-1:0]        interp;

  assign busy = (state != S_IDLE);

  // Writes are suppressed while reset is held so the clear sweep starts
  // cleanly on release.
  always_ff @(posedge clock) begin
    if (mem_we && reset_n) begin
      mem[mem_waddr] <= mem_wdata;
    end
    rd_data <= mem[mem_raddr];
  end

  // READ0 presents idx, READ1 presents idx+1; data arrives one cycle later.
  always_comb begin
    mem_raddr = idx_q;
    if (state == S_READ1) begin
      mem_raddr = idx_q + ADDRWIDTH'(1);
    end
  end

  always_comb begin
    state_next = state;
    mem_we     = 1'b0;
    mem_waddr  = wr_ptr;
    mem_wdata  = in_data;
    accept     = 1'b0;
    case (state)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_addr;
        mem_wdata = '0;
        if (&clr_addr) begin
          state_next = S_IDLE;
        end
      end
      S_IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          mem_we     = 1'b1;
          state_next = S_READ0;
        end
      end
      S_READ0: state_next = S_READ1;
      S_READ1: state_next = S_MUL;
      S_MUL:   state_next = S_OUT;
      S_OUT:   state_next = S_IDLE;
      default: state_next = S_CLEAR;
    endcase
  end

  // Interpolation: A + floor((B - A) * f / 2^FRACWIDTH). The result always
  // lies between A and B, so truncating back to DATAWIDTH cannot overflow.
  always_comb begin
    diff      = $signed({rd_data[DATAWIDTH-1], rd_data}) - $signed({a_q[DATAWIDTH-1], a_q});
    diff_ext  = {{(MW-DW1){diff[DW1-1]}}, diff};
    frac_ext  = {{(MW-FRACWIDTH){1'b0}}, frac_q};
    prod_next = diff_ext * frac_ext;
    shifted   = prod_q >>> FRACWIDTH;
    a_ext     = {{(MW-DATAWIDTH){a_q[DATAWIDTH-1]}}, a_q};
    interp    = DATAWIDTH'(a_ext + shifted);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= S_CLEAR;
      clr_addr  <= '0;
      wr_ptr    <= ADDRWIDTH'(DEPTH / 2);
      rd_phase  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      dropped   <= 1'b0;
    end else begin
      state     <= state_next;
      out_valid <= 1'b0;
      if (state == S_CLEAR) begin
        clr_addr <= clr_addr + ADDRWIDTH'(1);
      end
      if (in_valid && (state != S_IDLE)) begin
        dropped <= 1'b1;
      end
      if (accept) begin
        wr_ptr <= wr_ptr + ADDRWIDTH'(1);
      end
      if (state == S_OUT) begin
        out_data  <= interp;
        out_valid <= 1'b1;
        rd_phase  <= rd_phase + {{(PW-RATIOWIDTH){1'b0}}, ratio_q};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      idx_q   <= rd_phase[PW-1:FRACWIDTH];
      frac_q  <= rd_phase[FRACWIDTH-1:0];
      ratio_q <= ratio;
    end
    if (state == S_READ1) begin
      a_q <= $signed(rd_data);
    end
    if (state == S_MUL) begin
      prod_q <= prod_next;
    end
  end

endmodule

// File: tb/tb_pitch_read_interp.sv
// tb/tb_pitch_read_interp.sv - scoreboard bench for pitch_read_interp

module tb_pitch_read_interp;

  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int FW    = 8;
  localparam int RW    = 12;
  localparam int DEPTH = 1 << AW;
  localparam int FONE  = 1 << FW;
  localparam int PMOD  = 1 << (AW + FW);

  logic          clock    = 1'b0;
  logic          reset_n  = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data  = '0;
  logic [RW-1:0] ratio    = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          dropped;

  pitch_read_interp #(
    .DATAWIDTH (DW),
    .ADDRWIDTH (AW),
    .FRACWIDTH (FW),
    .RATIOWIDTH(RW)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .ratio    (ratio),
    .out_valid(out_valid),
    .out_data (out_data),
    .busy     (busy),
    .dropped  (dropped)
  );

  always #5 clock = ~clock;

  // Rising edges seen since reset was last released.
  int edge_n = 0;
  always @(posedge clock) begin
    if (!reset_n) edge_n <= 0;
    else          edge_n <= edge_n + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int data;
    int edge_no;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Reference model: buffer contents, pointers, and the edge after which the
  // reader is idle again.
  int mem_m [DEPTH];
  int wr_m;
  int ph_m;
  bit drop_m;
  int free_at;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 0;
    wr_m    = DEPTH / 2;
    ph_m    = 0;
    drop_m  = 1'b0;
    free_at = DEPTH;
  endtask

  function automatic int lerp(input int a, input int b, input int f);
    int p, q;
    p = (b - a) * f;
    q = p / FONE;
    if ((p < 0) && ((p % FONE) != 0)) q = q - 1;
    return a + q;
  endfunction

  // Drives one cycle of inputs; updates the model and scoreboard.
  task automatic drive(input bit v, input int data, input int r, input bit ovr, input int ovr_val);
    exp_t e;
    int idx, f, a, b;
    check("busy", busy, (edge_n < free_at));
    check("dropped", dropped, drop_m);
    in_valid = v;
    in_data  = DW'(data);
    ratio    = RW'(r);
    if (v) begin
      if (edge_n >= free_at) begin
        mem_m[wr_m] = data;
        wr_m = (wr_m + 1) % DEPTH;
        idx = ph_m / FONE;
        f   = ph_m % FONE;
        a   = mem_m[idx];
        b   = mem_m[(idx + 1) % DEPTH];
        e.data    = ovr ? ovr_val : lerp(a, b, f);
        e.edge_no = edge_n + 5;
        sb.push_back(e);
        ph_m    = (ph_m + r) % PMOD;
        free_at = edge_n + 5;
      end else begin
        drop_m = 1'b1;
      end
    end
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    while (edge_n < free_at) drive(1'b0, 0, 0, 1'b0, 0);
  endtask

  task automatic send(input int data, input int r, input bit ovr, input int ovr_val);
    wait_idle();
    drive(1'b1, data, r, ovr, ovr_val);
  endtask

  task automatic do_reset(input int ncyc);
    int n, bad;
    in_valid = 1'b0;
    reset_n  = 1'b0;
    sb.delete();
    model_reset();
    repeat (ncyc) @(negedge clock);
    check("rst_busy", busy, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_dropped", dropped, 0);
    reset_n = 1'b1;
    n   = 0;
    bad = 0;
    while (busy && (n < 2 * DEPTH)) begin
      n++;
      if (out_valid || (out_data != '0) || dropped) bad++;
      @(negedge clock);
    end
    check("clear_busy_cycles", n, DEPTH);
    check("clear_quiet", bad, 0);
  endtask

  // Monitor: pops one expectation per out_valid pulse.
  always @(negedge clock) begin
    if (reset_n) begin
      if ((sb.size() > 0) && (edge_n > sb[0].edge_no)) begin
        check("out_valid_late", edge_n, sb[0].edge_no);
        void'(sb.pop_front());
      end else if (out_valid) begin
        if (sb.size() == 0) begin
          check("out_valid_unexpected", out_valid, 0);
        end else begin
          mon_e = sb.pop_front();
          check("out_latency", edge_n, mon_e.edge_no);
          check("out_data", $signed(out_data), mon_e.data);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

  initial begin
    int d, r, ov;
    bit o;

    do_reset(3);

    // Unity ratio ramp, one sample every 8 cycles.
    for (int k = 1; k <= 520; k++) begin
      drive(1'b1, k, 'h100, 1'b0, 0);
      repeat (7) drive(1'b0, 0, 0, 1'b0, 0);
    end

    // Overrun: in_valid held for two cycles from idle.
    wait_idle();
    drive(1'b1, 1234, 'h100, 1'b0, 0);
    drive(1'b1, -777, 'h100, 1'b0, 0);
    repeat (6) drive(1'b0, 0, 0, 1'b0, 0);
    check("overrun_dropped", dropped, 1);

    // Random data, ratios and gaps (short gaps collide with busy).
    for (int i = 0; i < 400; i++) begin
      drive(1'b1, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 4095)), 1'b0, 0);
      repeat ($urandom_range(0, 6)) drive(1'b0, 0, 0, 1'b0, 0);
    end

    // Reset for one cycle during READ1 of a transaction.
    wait_idle();
    drive(1'b1, 4321, 'h300, 1'b0, 0);
    drive(1'b0, 0, 0, 1'b0, 0);
    do_reset(1);

    // Steer the read pointer onto hand-placed values, back-to-back samples.
    for (int n = 1; n <= 530; n++) begin
      d  = int'($urandom_range(0, 65535)) - 32768;
      r  = 272;
      o  = 1'b0;
      ov = 0;
      if (n <= 32) r = 4000;
      if (n == 33) r = 3200;
      if (n == 1) d = -100;
      if (n == 2) d = 101;
      if (n == 3) d = 10;
      if (n == 4) d = 20;
      if (n == 34) begin r = 448; o = 1'b1; ov = 0;  end
      if (n == 35) begin o = 1'b1; ov = 12; end
      if (n == 512) begin d = 0; r = 624; end
      if (n == 513) begin d = 1000; r = 512; o = 1'b1; ov = 500; end
      if (n > 513) r = int'($urandom_range(0, 4095));
      send(d, r, o, ov);
    end

    for (int i = 0; (i < 20) && (sb.size() > 0); i++) drive(1'b0, 0, 0, 1'b0, 0);
    check("drain_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pitch_read_interp.md
# pitch_read_interp

Fractional-rate delay-line reader for the pitch shifter. It owns a circular sample buffer that it writes at the input sample rate. For each input sample it reads the buffer at a fractional read pointer that advances by a programmable pitch ratio, and emits one linearly interpolated output sample. Integer-delay shift registers feed the buffer, and the crossfade stage consumes `out_data`.

## Interface
- `DATAWIDTH`, 16: signed sample width.
- `ADDRWIDTH`, 10: buffer address width; DEPTH = 2^ADDRWIDTH.
- `FRACWIDTH`, 8: fractional bits of read pointer and ratio.
- `RATIOWIDTH`, 12: ratio width, unsigned fixed point with FRACWIDTH fractional bits (1.0 = 2^FRACWIDTH).
- `clock` in 1: clock, rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: input sample strobe.
- `in_data` in DATAWIDTH: signed input sample.
- `ratio` in RATIOWIDTH: read-pointer increment per sample; sampled on acceptance.
- `out_valid` out 1: one-cycle output strobe.
- `out_data` out DATAWIDTH: signed interpolated sample; held between strobes.
- `busy` out 1: high in any state other than IDLE.
- `dropped` out 1: sticky flag, set when `in_valid` arrives while busy.

## Operation
- Storage:
  - mem[DEPTH] is a single-port-write, synchronous-read RAM with 1-cycle read latency.
  - The RAM itself is not reset; the CLEAR state zeroes it.
- Registers and reset values:
  - `wr_ptr` (ADDRWIDTH) resets to DEPTH/2.
  - `rd_phase` (P = ADDRWIDTH+FRACWIDTH bits) resets to 0.
  - Read index: idx = rd_phase[P-1:FRACWIDTH]. Fraction: f = rd_phase[FRACWIDTH-1:0].
- States:
  - **CLEAR**: entered while reset_n=0, with clr_addr=0. Each cycle with reset_n=1 writes 0 to mem[clr_addr] and increments it. After writing DEPTH-1, go to IDLE.
  - **IDLE**: on `in_valid`, write mem[wr_ptr] <= in_data, increment wr_ptr (mod DEPTH), latch idx, f and ratio, then go to READ0. Otherwise stay.
  - **READ0**: present address idx; go to READ1.
  - **READ1**: present address (idx+1) mod DEPTH; capture A = RAM data (from idx); go to MUL.
  - **MUL**: capture B = RAM data; register prod = (B−A)·f; go to OUT.
  - **OUT**: out_data <= A + (prod >>> FRACWIDTH); out_valid <= 1; rd_phase <= rd_phase + ratio (mod 2^P); go to IDLE.
- Arithmetic:
  - diff = B−A is signed, DATAWIDTH+1 bits.
  - f is zero-extended to FRACWIDTH+1 bits (signed positive).
  - prod is signed, DATAWIDTH+FRACWIDTH+2 bits.
  - `>>>` is an arithmetic shift (floor). The result always lies between A and B, so the final sum is truncated to DATAWIDTH with no overflow or saturation.
- Boundary conditions:
  - Read after write: a sample written in IDLE is visible to READ0/READ1 of the same transaction.
  - No guard against the read pointer crossing the write pointer; wrap of rd_phase and wr_ptr is silent.
  - idx = DEPTH−1 reads mem[DEPTH−1] and mem[0].
  - f = 0 gives out_data = A exactly.
  - `in_valid` while busy (any non-IDLE state, including CLEAR): the sample is discarded, no buffer write occurs, and dropped <= 1. dropped clears only on reset.
- Reset values:
  - out_valid = 0, out_data = 0, dropped = 0, busy = 1 (state CLEAR).
  - Reset asserted in any state aborts the transaction with no out_valid.

## Timing
- Clear phase: busy is high for DEPTH cycles after reset_n deasserts. The first acceptable `in_valid` comes DEPTH cycles after release (1024 for the default).
- Latency: `in_valid` accepted in cycle T gives out_valid high in cycle T+5, with out_data valid that cycle. busy is high T+1..T+4 and low at T+5.
- Throughput: one sample per 5 cycles maximum. An `in_valid` in cycle T+5 is accepted.
- out_valid is high exactly one cycle per accepted sample.

## Test plan
- **Clear:** release reset → busy=1 for exactly 1024 cycles, out_valid=0, out_data=0, dropped=0; then busy=0.
- **Unity ratio:** ratio=0x100, in_data ramp k=1,2,3…, one sample per 8 cycles → outputs 0 for the first 512 samples, then out_data = k−512.
- **Interpolation:** ADDRWIDTH=4, ratio=0x080, buffer locations i and i+1 hold −100 and 101, f=0x80 → out_data=0.
  - Same setup with values 10 and 20, f=0x40 → out_data=12.
- **Wrap:** drive rd_phase to idx=DEPTH−1, f=0x80, with mem[DEPTH−1]=0 and mem[0]=1000 → out_data=500. rd_phase wraps to a small value.
- **Overrun:** in_valid held high 2 cycles from IDLE → one out_valid only, dropped=1. Second sample is not written (wr_ptr advanced by 1).
- **Reset mid-op:** reset_n low for 1 cycle at T+2 of a transaction → no out_valid, busy=1, CLEAR reruns for 1024 cycles, dropped=0, rd_phase=0.
